// File: rtl/opsel_pkg.sv
// opsel_pkg: shared constants and select codes for the operand select stage
package opsel_pkg;
  localparam int OPSEL_WIDTH_DEF = 32;
  localparam int OPSEL_N_IN_DEF = 4;
  localparam int OPSEL_ERR_CNT_W = 8;
  typedef enum logic [1:0] {
    OPSEL_REG = 2'd0,
    OPSEL_IMM = 2'd1,
    OPSEL_PC = 2'd2,
    OPSEL_CONST4 = 2'd3
  } opsel_code_e;
endpackage

// File: rtl/operand_select_stage_if.sv
// operand_select_stage_if: producer/consumer handshake bundle of the operand select stage
interface operand_select_stage_if import opsel_pkg::*; #(
  parameter int WIDTH = OPSEL_WIDTH_DEF,
  parameter int N_IN = OPSEL_N_IN_DEF,
  parameter int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) ();
  logic in_valid;
  logic in_ready;
  logic [SEL_W-1:0] sel;
  logic [N_IN*WIDTH-1:0] opt_flat;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic out_sel_err;
  modport master (
    output in_valid, sel, opt_flat, out_ready,
    input in_ready, out_valid, result, out_sel_err
  );
  modport slave (
    input in_valid, sel, opt_flat, out_ready,
    output in_ready, out_valid, result, out_sel_err
  );
endinterface

// File: rtl/opsel_skid_buf.sv
// opsel_skid_buf: generic two-entry skid buffer owning the valid/ready handshake
module opsel_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic skid_v;
  logic [W-1:0] skid_d;
  logic acc;
  assign in_ready = ~skid_v;
  assign acc = in_valid & ~skid_v;
  // main drains first from skid, then from input; skid only fills while main is stalled
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_v | acc;
      out_data <= skid_v ? skid_d : acc ? in_data : out_data;
      skid_v <= 1'b0;
    end else if (acc) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
endmodule

// File: rtl/operand_select_stage.sv
// operand_select_stage: registered N_IN-way operand selector with skid handshake; OPSEL_ERR_COUNT_EN adds err_count
module operand_select_stage import opsel_pkg::*; #(
  parameter int WIDTH = OPSEL_WIDTH_DEF,
  parameter int N_IN = OPSEL_N_IN_DEF,
  parameter int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic clk,
  input  logic reset,
  operand_select_stage_if.slave bus,
  output logic err_sticky
`ifdef OPSEL_ERR_COUNT_EN
  ,
  output logic [OPSEL_ERR_CNT_W-1:0] err_count
`endif
);
  logic sel_ok;
  logic acc;
  logic [WIDTH-1:0] pick;
  logic [WIDTH:0] q;
  assign sel_ok = 32'(bus.sel) < N_IN;
  assign pick = sel_ok ? bus.opt_flat[32'(bus.sel)*WIDTH +: WIDTH] : '0;
  assign acc = bus.in_valid & bus.in_ready;
  assign bus.result = q[WIDTH-1:0];
  assign bus.out_sel_err = q[WIDTH];
  opsel_skid_buf #(.W(WIDTH + 1)) u_skid (
    .clk(clk),
    .reset(reset),
    .in_valid(bus.in_valid),
    .in_ready(bus.in_ready),
    .in_data({~sel_ok, pick}),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data(q)
  );
  // latch any accepted illegal select until reset
  always_ff @(posedge clk)
    if (reset) err_sticky <= 1'b0;
    else if (acc && !sel_ok) err_sticky <= 1'b1;
`ifdef OPSEL_ERR_COUNT_EN
  // saturating count of accepted illegal selects
  always_ff @(posedge clk)
    if (reset) err_count <= '0;
    else if (acc && !sel_ok && !(&err_count)) err_count <= err_count + 1'b1;
`endif
endmodule

// File: doc/operand_select_stage.md
Name: operand_select_stage

Overview:
- Parametrised, registered operand selector for the multicycle datapath.
- Picks one of N_IN WIDTH-bit candidate operands (register value, immediate, PC, constant, ...) and registers the choice.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the ALU-source stage can stall without losing operands.
- Flags out-of-range selects and carries the flag alongside the data.

Parameters:
- WIDTH, 32, bit width of each operand and of result.
- N_IN, 4, number of candidate operands; legal range 2..16.
- SEL_W, $clog2(N_IN), width of sel; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers sel plus operands this cycle.
- in_ready  output  1  stage can accept; registered, equals NOT skid_valid.
- sel  input  SEL_W  operand index; values >= N_IN are illegal.
- opt_flat  input  N_IN*WIDTH  candidate operands; operand k sits at bits [k*WIDTH +: WIDTH].
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  WIDTH  selected operand, registered.
- out_sel_err  output  1  the entry at the output had an illegal sel.
- err_sticky  output  1  set on any accepted illegal sel; cleared only by reset.

Behaviour:
- Clock and reset: single clock, clk. Synchronous active-high reset. At the reset edge: out_valid=0, result=0, out_sel_err=0, err_sticky=0, skid buffer empty, in_ready=1 on the following cycle.
- Reset mid-operation: both entries are discarded and nothing is emitted afterwards.
- Accept / release: accept = in_valid & in_ready; release = out_valid & out_ready.
- Select function: sel < N_IN gives opt_flat[sel]. sel >= N_IN gives 0 with err=1.
- Latency: a value accepted in cycle t appears on result with out_valid=1 in cycle t+1, provided the main register was empty or released in cycle t.
- Storage:
  - main register drives result, out_sel_err and out_valid.
  - skid register (data, err, skid_valid) holds one extra entry.
- Transitions per cycle:
  - main empty or release, skid empty: accepted data loads main; otherwise main clears valid on release.
  - main full, no release, accept: data goes to skid; skid_valid=1; in_ready=0 next cycle.
  - release with skid full: skid moves to main; skid_valid=0. No accept is possible, since in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, result and out_sel_err must not change.
- Ordering: strict FIFO, no reordering, no drops, no duplicates.
- in_ready is a register output and never depends combinationally on out_ready.
- Inputs are ignored when in_valid=0 or in_ready=0.
- Sticky error: err_sticky sets in the cycle after an accepted illegal sel.
- Power-of-two N_IN: no illegal codes exist and out_sel_err stays 0.

Optional Feature:
- Macro: OPSEL_ERR_COUNT_EN.
- Defined:
  - Adds output port err_count (8 bits).
  - Increments on each accepted illegal sel; saturates at 255; reset to 0.
- Undefined:
  - Port absent, no counter logic.
  - err_sticky behaviour unchanged.

Decomposition:
- Package opsel_pkg:
  - Constants OPSEL_WIDTH_DEF=32 and OPSEL_N_IN_DEF=4.
  - Named select codes for the ALU-source datapath: OPSEL_REG=0, OPSEL_IMM=1, OPSEL_PC=2, OPSEL_CONST4=3.
  - OPSEL_ERR_CNT_W=8.
- Sub-module opsel_skid_buf:
  - Generic WIDTH+1-bit 2-entry skid buffer owning the handshake.
  - The top holds the select/error logic and the sticky/counter state.

Test Plan:
- Reset, then sel=2 with operands {10,20,30,40}, in_valid=1, out_ready=1 -> next cycle result=30, out_valid=1, out_sel_err=0.
- Back-to-back: sel=0,1,2,3 on four consecutive cycles with out_ready=1 -> results 10,20,30,40 on the next four cycles, in_ready stays 1.
- Stall: out_ready=0, send sel=1 then sel=3 -> result holds 20, in_ready=0 after the second accept. Raise out_ready -> 20 then 40 released, in_ready returns to 1.
- Illegal select: N_IN=3, sel=3 -> result=0, out_sel_err=1, err_sticky=1 and stays 1; err_count=1 when OPSEL_ERR_COUNT_EN is defined.
- Reset with main and skid both full -> out_valid=0 and err_sticky=0 next cycle, stale data never appears.
- Randomised valid/ready with 1000 transactions -> output sequence equals a scoreboard model, no loss or duplication.
